// File: rtl/dpi_mem_ctrl_hs_pkg.sv
// rtl/dpi_mem_ctrl_hs_pkg.sv - state enum and host memory model shared by the controller
// The pmem_read/pmem_write model is word indexed and aliases every 16 KiB.
package dpi_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_state_e;

  localparam int unsigned MEM_WORDS = 4096;

  logic [31:0] pmem [MEM_WORDS];
  int unsigned pmem_read_calls;
  int unsigned pmem_write_calls;
  logic [7:0]  pmem_last_wmask;

  function automatic logic [11:0] pmem_idx(input logic [31:0] addr);
    return 12'(addr >> 2);
  endfunction

  function automatic logic [31:0] pmem_read(input logic [31:0] addr);
    pmem_read_calls = pmem_read_calls + 1;
    return pmem[pmem_idx(addr)];
  endfunction

  function automatic void pmem_write(input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [7:0] wmask);
    pmem_write_calls = pmem_write_calls + 1;
    pmem_last_wmask  = wmask;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) pmem[pmem_idx(addr)][8*b +: 8] = wdata[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/dpi_mem_ctrl_hs_lfsr16.sv
// rtl/dpi_mem_ctrl_hs_lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) for access latency
module lfsr16
  (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
  );

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/dpi_mem_ctrl_hs.sv
// rtl/dpi_mem_ctrl_hs.sv - handshaked host memory controller with fixed or random latency
// One transaction in flight; each memory call is issued once, in the ACCESS cycle.
module dpi_mem_ctrl_hs
  import dpi_mem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LAT_MIN   = 1,
  parameter int          LAT_MAX   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int NBEATS   = DATA_W / 32;
  localparam int OFS_W    = $clog2(NBYTES);
  localparam int LAT_SPAN = LAT_MAX - LAT_MIN + 1;
  localparam int CNT_W    = $clog2(LAT_MAX + 2);

  mem_state_e          state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic                err_q;
  logic                wen_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [NBYTES-1:0]   wstrb_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [15:0]         lfsr;
  logic [31:0]         addr_aligned;
  logic [32:0]         beat_end;
  logic [32:0]         mem_end;
  logic                addr_err;
  logic [CNT_W-1:0]    cnt_load;
  logic                unused_addr_lsb;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  assign unused_addr_lsb = ^req_addr[OFS_W-1:0];
  assign addr_aligned    = {req_addr[31:OFS_W], {OFS_W{1'b0}}};

  // The whole beat must fit; 33-bit sums keep the top of the address space from wrapping.
  assign beat_end = {1'b0, addr_aligned} + 33'(NBYTES);
  assign mem_end  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  assign addr_err = (addr_aligned < MEM_BASE) || (beat_end > mem_end);
  assign cnt_load = CNT_W'(32'(LAT_MIN) + ({16'b0, lfsr} % 32'(LAT_SPAN)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      err_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            req_ready_q <= 1'b0;
            wen_q       <= req_wen;
            addr_q      <= addr_aligned;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            err_q       <= addr_err;
            cnt_q       <= cnt_load;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= ACCESS;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ACCESS: begin
          rdata_q <= '0;
          if (!err_q) begin
            for (int b = 0; b < NBEATS; b++) begin
              if (wen_q) begin
                if (|wstrb_q[4*b +: 4])
                  pmem_write(addr_q + 32'(4*b), wdata_q[32*b +: 32], {4'b0, wstrb_q[4*b +: 4]});
              end else begin
                rdata_q[32*b +: 32] <= pmem_read(addr_q + 32'(4*b));
              end
            end
          end
          resp_err_q   <= err_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dpi_mem_ctrl_hs.sv
// tb/tb_dpi_mem_ctrl_hs.sv - directed bench for dpi_mem_ctrl_hs (fixed and random latency)
module tb_dpi_mem_ctrl_hs;
  import dpi_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid_a, req_valid_b, req_wen, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
  logic [31:0] resp_rdata_a, resp_rdata_b;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dpi_mem_ctrl_hs #(.DATA_W(32), .LAT_MIN(2), .LAT_MAX(2)) dut (
    .clock(clk), .reset(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a)
  );

  dpi_mem_ctrl_hs #(.DATA_W(32), .LAT_MIN(1), .LAT_MAX(4)) dut_r (
    .clock(clk), .reset(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b)
  );

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
    int          nrd;
    int          nwr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic logic rdy(input bit s);
    return s ? req_ready_b : req_ready_a;
  endfunction
  function automatic logic rvld(input bit s);
    return s ? resp_valid_b : resp_valid_a;
  endfunction
  function automatic logic [31:0] rdat(input bit s);
    return s ? resp_rdata_b : resp_rdata_a;
  endfunction
  function automatic logic rerr(input bit s);
    return s ? resp_err_b : resp_err_a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input bit s, input bit wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, output bit ok);
    int cyc = 0;
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    if (s) req_valid_b = 1'b1;
    else   req_valid_a = 1'b1;
    while (!rdy(s) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    ok = rdy(s);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready got 0, expected 1");
    end else begin
      @(posedge clk); #1;
    end
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_resp(input bit s, output int lat);
    lat = 0;
    while (!rvld(s) && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    if (!rvld(s)) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid got 0 after %0d cycles, expected 1", lat);
      lat = -1;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd0, wr0;
    int          lat;
    bit          ok;
    logic [3:0]  seen;
    logic [31:0] raddr [4];
    logic [31:0] rexp  [4];

    vecs[0]  = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0, 1};
    vecs[1]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1, 0};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0, 0, 1};
    vecs[3]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0, 0, 1};
    vecs[4]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0, 1, 0};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1, 0, 0};
    vecs[6]  = '{1'b1, 32'h8000_0021, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, 0, 1};
    vecs[7]  = '{1'b0, 32'h8000_0022, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 32'h87FF_FFFC, 32'h5A5A_0001, 4'hF, 32'h0,         1'b0, 0, 1};
    vecs[9]  = '{1'b0, 32'h87FF_FFFC, 32'h0,         4'h0, 32'h5A5A_0001, 1'b0, 1, 0};
    vecs[10] = '{1'b0, 32'h8800_0000, 32'h0,         4'h0, 32'h0,         1'b1, 0, 0};
    vecs[11] = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 0, 0};
    vecs[12] = '{1'b0, 32'h87FF_FFFC, 32'h0,         4'h0, 32'h5A5A_0001, 1'b0, 1, 0};
    vecs[13] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0, 0};
    vecs[14] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0, 1, 0};

    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready_a}, 32'd0);
    chk("reset_resp_valid", {31'b0, resp_valid_a}, 32'd0);
    chk("reset_rdata", resp_rdata_a, 32'd0);
    chk("reset_err", {31'b0, resp_err_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_req_ready", {31'b0, req_ready_a}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      rd0 = pmem_read_calls; wr0 = pmem_write_calls;
      send_req(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, ok);
      if (ok) begin
        wait_resp(1'b0, lat);
        if (lat >= 0) begin
          chk($sformatf("v%0d_rdata", i), resp_rdata_a, vecs[i].rdata);
          chk($sformatf("v%0d_err", i), {31'b0, resp_err_a}, {31'b0, vecs[i].err});
          chk($sformatf("v%0d_latency", i), lat, 32'd4);
          chk($sformatf("v%0d_read_calls", i), pmem_read_calls - rd0, vecs[i].nrd);
          chk($sformatf("v%0d_write_calls", i), pmem_write_calls - wr0, vecs[i].nwr);
          if (i == 3) chk("v3_wmask", {24'b0, pmem_last_wmask}, 32'h05);
          ack();
        end
      end
    end

    // Response held off for five cycles, then handshake and no same-cycle re-accept.
    rd0 = pmem_read_calls;
    send_req(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, ok);
    if (ok) begin
      wait_resp(1'b0, lat);
      if (lat >= 0) begin
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("hold%0d_valid", k), {31'b0, resp_valid_a}, 32'd1);
          chk($sformatf("hold%0d_rdata", k), resp_rdata_a, 32'hDEAD_BEEF);
          chk($sformatf("hold%0d_req_ready", k), {31'b0, req_ready_a}, 32'd0);
          @(posedge clk); #1;
        end
        chk("hold_read_calls", pmem_read_calls - rd0, 32'd1);
        ack();
        chk("after_ack_valid", {31'b0, resp_valid_a}, 32'd0);
        chk("after_ack_req_ready", {31'b0, req_ready_a}, 32'd0);
        @(posedge clk); #1;
        chk("after_ack_req_ready_next", {31'b0, req_ready_a}, 32'd1);
      end
    end

    // Reset while in WAIT aborts the write.
    wr0 = pmem_write_calls;
    send_req(1'b0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_resp_valid", {31'b0, resp_valid_a}, 32'd0);
    chk("abort_req_ready_reset_cycle", {31'b0, req_ready_a}, 32'd0);
    @(posedge clk); #1;
    chk("abort_req_ready_after", {31'b0, req_ready_a}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_write_calls", pmem_write_calls - wr0, 32'd0);
    send_req(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, ok);
    if (ok) begin
      wait_resp(1'b0, lat);
      if (lat >= 0) begin
        chk("abort_readback", resp_rdata_a, 32'hDEAD_BEEF);
        ack();
      end
    end

    // Random latency: 200 reads on the LAT_MIN=1, LAT_MAX=4 instance.
    raddr[0] = 32'h8000_0004; rexp[0] = 32'hDEAD_BEEF;
    raddr[1] = 32'h8000_0010; rexp[1] = 32'hAA22_CC44;
    raddr[2] = 32'h8000_0020; rexp[2] = 32'h0BAD_F00D;
    raddr[3] = 32'h87FF_FFFC; rexp[3] = 32'h5A5A_0001;
    seen = '0;
    rd0  = pmem_read_calls;
    for (int n = 0; n < 200; n++) begin
      send_req(1'b1, 1'b0, raddr[n % 4], 32'h0, 4'h0, ok);
      if (ok) begin
        wait_resp(1'b1, lat);
        if (lat >= 0) begin
          chk($sformatf("rnd%0d_rdata", n), rdat(1'b1), rexp[n % 4]);
          chk($sformatf("rnd%0d_err", n), {31'b0, rerr(1'b1)}, 32'd0);
          chk($sformatf("rnd%0d_lat_in_range", n), {31'b0, (lat >= 3 && lat <= 6)}, 32'd1);
          if (lat >= 3 && lat <= 6) seen[lat-3] = 1'b1;
          ack();
        end
      end
      repeat (n % 3) @(posedge clk);
      #1;
    end
    chk("rnd_latencies_seen", {28'b0, seen}, 32'h0000_000F);
    chk("rnd_read_calls", pmem_read_calls - rd0, 32'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
